// File: rtl/dm_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-port data memory with
// round-robin fairness, bounded lock ownership and a one-cycle read return path.
module dm_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 5,
  parameter int MAX_LOCK      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_req,
  input  logic                     a_we,
  input  logic                     a_lock,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  input  logic                     b_req,
  input  logic                     b_we,
  input  logic                     b_lock,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  output logic                     a_gnt,
  output logic                     b_gnt,
  output logic                     a_rvalid,
  output logic                     b_rvalid,
  output logic [DATA_WIDTH-1:0]    a_rdata,
  output logic [DATA_WIDTH-1:0]    b_rdata,
  output logic                     mem_write,
  output logic                     mem_read,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

  state_e                state_q, state_d;
  logic                  last_b_q, last_b_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_own_b_q, rd_own_b_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic                  granted;
  logic                  we_sel;

  // Grant decision: lock owner is served exclusively; otherwise round-robin on ties.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      case (state_q)
        LOCK_A:  a_gnt = a_req;
        LOCK_B:  b_gnt = b_req;
        default: begin
          if (a_req && b_req) begin
            a_gnt = last_b_q;
            b_gnt = !last_b_q;
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
        end
      endcase
    end
  end

  assign granted   = a_gnt | b_gnt;
  assign we_sel    = b_gnt ? b_we : a_we;
  assign mem_write = granted & we_sel;
  assign mem_read  = granted & ~we_sel;
  assign mem_addr  = a_gnt ? a_addr  : (b_gnt ? b_addr  : '0);
  assign mem_wdata = a_gnt ? a_wdata : (b_gnt ? b_wdata : '0);

  assign a_rvalid = rd_pend_q & ~rd_own_b_q & ~rst;
  assign b_rvalid = rd_pend_q &  rd_own_b_q & ~rst;
  assign a_rdata  = a_rvalid ? mem_rdata : a_rdata_q;
  assign b_rdata  = b_rvalid ? mem_rdata : b_rdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_b_d   = last_b_q;
    rd_pend_d  = mem_read;
    rd_own_b_d = b_gnt;
    if (a_gnt) last_b_d = 1'b0;
    if (b_gnt) last_b_d = 1'b1;
    case (state_q)
      LOCK_A: begin
        if (!a_gnt) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (!a_lock || cnt_d >= MAX_CNT) state_d = IDLE;
        end
      end
      LOCK_B: begin
        if (!b_gnt) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (!b_lock || cnt_d >= MAX_CNT) state_d = IDLE;
        end
      end
      default: begin
        // A one-grant lock budget is already exhausted by the granting access.
        if (a_gnt && a_lock && MAX_CNT > 4'd1) begin
          state_d = LOCK_A;
          cnt_d   = 4'd1;
        end else if (b_gnt && b_lock && MAX_CNT > 4'd1) begin
          state_d = LOCK_B;
          cnt_d   = 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      cnt_q      <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_own_b_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_own_b_q <= rd_own_b_d;
      if (a_rvalid) a_rdata_q <= mem_rdata;
      if (b_rvalid) b_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, lock/reset sequences and a
// randomized run against a transaction-level reference model with its own memory image.
module tb_dm_arbiter;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int MAXL = 8;

  logic clk = 1'b0;
  logic rst;
  logic a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write, mem_read;
  logic [DW-1:0] a_rdata, b_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  dm_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory with a registered read port.
  logic [DW-1:0] tbmem [32];
  always @(posedge clk) begin
    if (mem_write) tbmem[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= tbmem[mem_addr];
  end

  int errors = 0;
  int checks = 0;

  // Reference model: ports numbered 1 (A) and 2 (B), 0 = none.
  int m_lock = 0;
  int m_used = 0;
  int m_last = 2;
  int m_pend = 0;
  logic [DW-1:0] m_pend_data = '0;
  logic [DW-1:0] m_rd [3];
  logic [DW-1:0] shadow [32];

  logic cap_ga, cap_gb, cap_rva, cap_rvb, cap_mr, cap_mw;
  logic [DW-1:0] cap_rda, cap_rdb, cap_mwd;
  logic [AW-1:0] cap_ma;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_g();
    if (rst) return 0;
    if (m_lock == 1) return a_req ? 1 : 0;
    if (m_lock == 2) return b_req ? 2 : 0;
    if (a_req && b_req) return (m_last == 1) ? 2 : 1;
    if (a_req) return 1;
    if (b_req) return 2;
    return 0;
  endfunction

  task automatic model_check();
    int g;
    logic we;
    g = exp_g();
    we = (g == 2) ? b_we : a_we;
    chk("m a_gnt", a_gnt, g == 1);
    chk("m b_gnt", b_gnt, g == 2);
    chk("m mem_write", mem_write, g != 0 && we);
    chk("m mem_read", mem_read, g != 0 && !we);
    if (g != 0 || rst) begin
      chk("m mem_addr", mem_addr, g == 1 ? a_addr : (g == 2 ? b_addr : '0));
      chk("m mem_wdata", mem_wdata, g == 1 ? a_wdata : (g == 2 ? b_wdata : '0));
    end
    chk("m a_rvalid", a_rvalid, !rst && m_pend == 1);
    chk("m b_rvalid", b_rvalid, !rst && m_pend == 2);
    if (!rst) begin
      chk("m a_rdata", a_rdata, m_pend == 1 ? m_pend_data : m_rd[1]);
      chk("m b_rdata", b_rdata, m_pend == 2 ? m_pend_data : m_rd[2]);
    end
  endtask

  task automatic model_update();
    int g;
    logic we, lk;
    int ad;
    logic [DW-1:0] wd;
    g = exp_g();
    if (rst) begin
      m_lock = 0; m_used = 0; m_last = 2; m_pend = 0;
      m_rd[1] = '0; m_rd[2] = '0;
      return;
    end
    if (m_pend != 0) m_rd[m_pend] = m_pend_data;
    lk = (g == 1) ? a_lock : b_lock;
    if (m_lock != 0) begin
      if (g == 0) m_lock = 0;
      else begin
        m_used++;
        if (!lk || m_used >= MAXL) m_lock = 0;
      end
    end else if (g != 0 && lk && MAXL > 1) begin
      m_lock = g;
      m_used = 1;
    end
    m_pend = 0;
    if (g != 0) begin
      m_last = g;
      we = (g == 1) ? a_we : b_we;
      ad = (g == 1) ? int'(a_addr) : int'(b_addr);
      wd = (g == 1) ? a_wdata : b_wdata;
      if (we) shadow[ad] = wd;
      else begin
        m_pend = g;
        m_pend_data = shadow[ad];
      end
    end
  endtask

  task automatic drv(input bit r, input bit ar, input bit awe, input bit alk, input int aad,
                     input int awd, input bit br, input bit bwe, input bit blk, input int bad,
                     input int bwd);
    rst = r;
    a_req = ar; a_we = awe; a_lock = alk; a_addr = AW'(aad); a_wdata = DW'(awd);
    b_req = br; b_we = bwe; b_lock = blk; b_addr = AW'(bad); b_wdata = DW'(bwd);
  endtask

  task automatic cyc();
    @(negedge clk);
    model_check();
    cap_ga = a_gnt; cap_gb = b_gnt; cap_rva = a_rvalid; cap_rvb = b_rvalid;
    cap_rda = a_rdata; cap_rdb = b_rdata; cap_mr = mem_read; cap_mw = mem_write;
    cap_ma = mem_addr; cap_mwd = mem_wdata;
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    bit rst;
    bit ar, awe, alk; int aad, awd;
    bit br, bwe, blk; int bad, bwd;
    bit ega, egb, erva, ervb; int erd;
  } vec_t;

  function automatic vec_t v(bit r, bit ar, bit awe, bit alk, int aad, int awd,
                             bit br, bit bwe, bit blk, int bad, int bwd,
                             bit ega, bit egb, bit erva, bit ervb, int erd);
    vec_t x;
    x.rst = r; x.ar = ar; x.awe = awe; x.alk = alk; x.aad = aad; x.awd = awd;
    x.br = br; x.bwe = bwe; x.blk = blk; x.bad = bad; x.bwd = bwd;
    x.ega = ega; x.egb = egb; x.erva = erva; x.ervb = ervb; x.erd = erd;
    return x;
  endfunction

  vec_t vq[$];
  bit rq[2], rwe[2], rlk[2];
  int rad[2], rwd[2];
  int na;

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbmem[i] = DW'(i * 7 + 1);
    end
    tbmem[1] = 8'h11; tbmem[2] = 8'h22; tbmem[3] = 8'h5A;
    for (int i = 0; i < 32; i++) shadow[i] = tbmem[i];
    m_rd[0] = '0; m_rd[1] = '0; m_rd[2] = '0;

    //          rst ar we lk ad  wd     br we lk ad  wd     ga gb va vb rd
    vq.push_back(v(1, 0,0,0, 0, 0,     0,0,0, 0, 0,      0,0,0,0, 0));
    vq.push_back(v(1, 0,0,0, 0, 0,     0,0,0, 0, 0,      0,0,0,0, 0));
    vq.push_back(v(0, 1,0,0, 3, 0,     0,0,0, 0, 0,      1,0,0,0, 0));
    vq.push_back(v(0, 0,0,0, 0, 0,     0,0,0, 0, 0,      0,0,1,0, 'h5A));
    vq.push_back(v(0, 0,0,0, 0, 0,     1,1,0, 7, 'h3C,   0,1,0,0, 0));
    vq.push_back(v(0, 1,0,0, 7, 0,     0,0,0, 0, 0,      1,0,0,0, 0));
    vq.push_back(v(0, 0,0,0, 0, 0,     0,0,0, 0, 0,      0,0,1,0, 'h3C));
    vq.push_back(v(0, 1,0,0, 1, 0,     0,0,0, 0, 0,      1,0,0,0, 0));
    vq.push_back(v(0, 0,0,0, 0, 0,     1,0,0, 2, 0,      0,1,1,0, 'h11));
    vq.push_back(v(0, 1,0,0, 1, 0,     0,0,0, 0, 0,      1,0,0,1, 'h22));
    vq.push_back(v(0, 0,0,0, 0, 0,     1,0,0, 2, 0,      0,1,1,0, 'h11));
    vq.push_back(v(0, 0,0,0, 0, 0,     0,0,0, 0, 0,      0,0,0,1, 'h22));
    vq.push_back(v(1, 0,0,0, 0, 0,     0,0,0, 0, 0,      0,0,0,0, 0));
    vq.push_back(v(0, 1,1,0, 0, 'hA0,  1,1,0, 31,'hB0,   1,0,0,0, 0));
    vq.push_back(v(0, 1,1,0, 0, 'hA1,  1,1,0, 31,'hB0,   0,1,0,0, 0));
    vq.push_back(v(0, 1,1,0, 0, 'hA1,  1,1,0, 31,'hB1,   1,0,0,0, 0));
    vq.push_back(v(0, 1,1,0, 0, 'hA2,  1,1,0, 31,'hB1,   0,1,0,0, 0));
    vq.push_back(v(0, 0,0,0, 0, 0,     0,0,0, 0, 0,      0,0,0,0, 0));

    foreach (vq[i]) begin
      drv(vq[i].rst, vq[i].ar, vq[i].awe, vq[i].alk, vq[i].aad, vq[i].awd,
          vq[i].br, vq[i].bwe, vq[i].blk, vq[i].bad, vq[i].bwd);
      cyc();
      chk($sformatf("v%0d a_gnt", i), cap_ga, vq[i].ega);
      chk($sformatf("v%0d b_gnt", i), cap_gb, vq[i].egb);
      chk($sformatf("v%0d a_rvalid", i), cap_rva, vq[i].erva);
      chk($sformatf("v%0d b_rvalid", i), cap_rvb, vq[i].ervb);
      if (vq[i].erva) chk($sformatf("v%0d a_rdata", i), cap_rda, vq[i].erd);
      if (vq[i].ervb) chk($sformatf("v%0d b_rdata", i), cap_rdb, vq[i].erd);
      if (vq[i].ega && !vq[i].awe) chk($sformatf("v%0d mem_addr", i), cap_ma, vq[i].aad);
    end

    // Locked writer against a continuously requesting B: 8 A grants, then B, then A.
    drv(1, 0,0,0,0,0, 0,0,0,0,0);
    cyc();
    na = 0;
    for (int i = 0; i < 10; i++) begin
      drv(0, 1,1,1, na, 'h50 + na, 1,1,0, 20, 'h66);
      cyc();
      chk($sformatf("lock%0d a_gnt", i), cap_ga, i != 8);
      chk($sformatf("lock%0d b_gnt", i), cap_gb, i == 8);
      if (cap_ga) na++;
    end

    // Reset right after a granted read, and reset in the middle of a B lock.
    drv(1, 0,0,0,0,0, 0,0,0,0,0);
    cyc();
    drv(0, 1,0,0,3,0, 0,0,0,0,0);
    cyc();
    chk("rst_rd a_gnt", cap_ga, 1);
    chk("rst_rd mem_read", cap_mr, 1);
    drv(1, 0,0,0,0,0, 0,0,0,0,0);
    cyc();
    chk("rst_rd a_rvalid", cap_rva, 0);
    chk("rst_rd mem_read0", cap_mr, 0);
    drv(0, 0,0,0,0,0, 0,0,0,0,0);
    cyc();
    chk("rst_rd a_rvalid after", cap_rva, 0);
    drv(0, 0,0,0,0,0, 1,1,1,5,'h77);
    cyc();
    chk("lockb enter b_gnt", cap_gb, 1);
    drv(0, 1,1,0,6,'h88, 1,1,1,5,'h78);
    cyc();
    chk("lockb hold b_gnt", cap_gb, 1);
    chk("lockb hold a_gnt", cap_ga, 0);
    drv(1, 1,1,0,6,'h88, 1,1,1,5,'h79);
    cyc();
    chk("lockb rst gnts", {cap_ga, cap_gb, cap_mr, cap_mw}, 0);
    chk("lockb rst addr", {cap_ma, cap_mwd}, 0);
    drv(0, 1,1,0,6,'h88, 1,1,0,5,'h79);
    cyc();
    chk("post rst tie a_gnt", cap_ga, 1);
    chk("post rst tie b_gnt", cap_gb, 0);

    // Randomized traffic; requests stay stable until granted.
    for (int p = 0; p < 2; p++) rq[p] = 0;
    for (int c = 0; c < 2000; c++) begin
      bit rs;
      for (int p = 0; p < 2; p++) begin
        if (!rq[p] && $urandom_range(0, 9) < 8) begin
          rq[p] = 1;
          rwe[p] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 5) == 0) rlk[p] = !rlk[p];
          rad[p] = $urandom_range(0, 31);
          rwd[p] = $urandom_range(0, 255);
        end
      end
      rs = ($urandom_range(0, 79) == 0);
      drv(rs, rq[0], rwe[0], rlk[0], rad[0], rwd[0], rq[1], rwe[1], rlk[1], rad[1], rwd[1]);
      cyc();
      if (cap_ga) rq[0] = 0;
      if (cap_gb) rq[1] = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data word width.
REQ-002 Parameter ADDRESS_WIDTH, default 5, SHALL set the address width.
REQ-003 Parameter MAX_LOCK, default 8, SHALL set the maximum consecutive grants under lock (range 1..15).
REQ-004 clk  in  1  SHALL be the only clock; all state updates occur on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 a_req, b_req  in  1 each  SHALL request one memory access from port A (CPU) or port B (DMA/loader).
REQ-007 a_we, b_we  in  1 each  SHALL select write (1) or read (0).
REQ-008 a_lock, b_lock  in  1 each  SHALL request retention of ownership for back-to-back accesses.
REQ-009 a_addr, b_addr  in  ADDRESS_WIDTH each  SHALL give the access address.
REQ-010 a_wdata, b_wdata  in  DATA_WIDTH each  SHALL give the write data.
REQ-011 a_gnt, b_gnt  out  1 each  SHALL pulse high in the cycle the port's access is issued to memory.
REQ-012 a_rvalid, b_rvalid  out  1 each  SHALL pulse high when that port's read data is valid.
REQ-013 a_rdata, b_rdata  out  DATA_WIDTH each  SHALL carry read data, qualified by the matching rvalid.
REQ-014 mem_write, mem_read  out  1 each  SHALL drive the data memory write and read enables.
REQ-015 mem_addr  out  ADDRESS_WIDTH, mem_wdata  out  DATA_WIDTH  SHALL drive memory address and write data.
REQ-016 mem_rdata  in  DATA_WIDTH  SHALL be the memory's registered read output (valid one cycle after mem_read).

Function
REQ-017 At most one access SHALL be issued per cycle; gnt, mem_* outputs are combinational from current requests and registered state.
REQ-018 Issued access: mem_write=we, mem_read=~we, mem_addr/mem_wdata from the granted port; both enables 0 when no grant.
REQ-019 A requester SHALL hold req, we, addr, wdata, lock stable until it sees its gnt; gnt is never asserted without req.
REQ-020 FSM states IDLE, LOCK_A, LOCK_B; IDLE uses round-robin with a last-granted pointer; single requester always wins.
REQ-021 IDLE, both requesting: grant the port not equal to last-granted; pointer updates to the granted port on every grant.
REQ-022 IDLE -> LOCK_x when port x is granted with x_lock=1; lock counter loads 1.
REQ-023 LOCK_x: x_req=1 -> grant x regardless of other port; counter increments per grant.
REQ-024 LOCK_x -> IDLE when x_req=0 or x_lock=0 at a grant or counter reaches MAX_LOCK; same-cycle arbitration then follows IDLE rules for the next cycle.
REQ-025 LOCK_x with x_req=0: no grant to x; other port MAY NOT be granted that cycle; FSM returns to IDLE next cycle.
REQ-026 Counter reaching MAX_LOCK with other port requesting: next grant SHALL go to other port (starvation bound MAX_LOCK+1 cycles).
REQ-027 Read latency: x_rvalid SHALL assert exactly one cycle after x_gnt for a read, with x_rdata=mem_rdata that cycle; writes produce no rvalid.
REQ-028 Read-owner tag SHALL be registered; back-to-back reads from alternating ports SHALL each return correct data on consecutive cycles.
REQ-029 Non-valid x_rdata SHALL hold its last valid value.

Reset
REQ-030 While rst=1: all gnt, mem_write, mem_read, rvalid SHALL be 0; mem_addr, mem_wdata 0.
REQ-031 After rst: state IDLE, last-granted pointer = B (A wins first tie), lock counter 0, a_rdata=b_rdata=0.
REQ-032 A read granted in the cycle before rst SHALL NOT produce rvalid; reset mid-lock SHALL return to IDLE.

Verification
REQ-033 Only a_req read addr 3, memory[3]=0x5A -> a_gnt cycle T, mem_read=1, mem_addr=3; a_rvalid at T+1, a_rdata=0x5A.
REQ-034 After reset a_req and b_req both held continuously (no lock) -> grants A,B,A,B on consecutive cycles.
REQ-035 A locks with 12 continuous writes, b_req held, MAX_LOCK=8 -> A granted 8 consecutive cycles, then B granted, then A.
REQ-036 b_req write addr 7 data 0x3C, then a_req read addr 7 -> mem_write cycle T, a_rvalid T+2 with a_rdata=0x3C.
REQ-037 Alternating A read addr 1 (0x11) and B read addr 2 (0x22) -> a_rvalid/0x11 and b_rvalid/0x22 on consecutive cycles, never both.
REQ-038 rst asserted the cycle after a_gnt read, and during LOCK_B -> no a_rvalid, all outputs 0, next tie grants A.
